// File: rtl/button_sequencer.sv
// Front-panel controller: edge-detects four debounced buttons, arbitrates them and runs the set-mode FSM.
// 1 clk latency from press detect to registered event; no backpressure, losing presses are dropped.
module button_sequencer #(
  parameter int HOLD_TICKS    = 50,
  parameter int REPEAT_TICKS  = 10,
  parameter int TIMEOUT_TICKS = 1000,
  parameter int CNT_W         = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_alarm,
  output logic [2:0] mode,
  output logic       inc_pulse,
  output logic       dec_pulse,
  output logic       alarm_en
);

  localparam logic [2:0] NORMAL     = 3'd0;
  localparam logic [2:0] SET_HR     = 3'd1;
  localparam logic [2:0] SET_MIN    = 3'd2;
  localparam logic [2:0] SET_AL_HR  = 3'd3;
  localparam logic [2:0] SET_AL_MIN = 3'd4;

  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_TICKS - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST  = CNT_W'(REPEAT_TICKS - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_TICKS - 1);

  logic             prev_mode, prev_up, prev_down, prev_alarm;
  logic             press_mode, press_up, press_down, press_alarm;
  logic             in_set;
  logic [CNT_W-1:0] hold_cnt, hold_nxt;
  logic [CNT_W-1:0] to_cnt, to_nxt;
  logic             repeating, rep_nxt, rep_fire, timeout;
  logic [2:0]       mode_nxt, mode_adv;
  logic             inc_nxt, dec_nxt, alarm_nxt;

  assign press_mode  = btn_mode  & ~prev_mode;
  assign press_up    = btn_up    & ~prev_up;
  assign press_down  = btn_down  & ~prev_down;
  assign press_alarm = btn_alarm & ~prev_alarm;
  assign in_set      = (mode != NORMAL) && (mode <= SET_AL_MIN);

  always_comb begin
    case (mode)
      NORMAL:    mode_adv = SET_HR;
      SET_HR:    mode_adv = SET_MIN;
      SET_MIN:   mode_adv = SET_AL_HR;
      SET_AL_HR: mode_adv = SET_AL_MIN;
      default:   mode_adv = NORMAL;
    endcase
  end

  // One counter serves both phases: initial hold delay, then the repeat interval.
  always_comb begin
    hold_nxt = hold_cnt;
    rep_nxt  = repeating;
    rep_fire = 1'b0;
    if (!in_set || !(btn_up ^ btn_down)) begin
      hold_nxt = '0;
      rep_nxt  = 1'b0;
    end else if (tick) begin
      if (hold_cnt >= (repeating ? REPEAT_LAST : HOLD_LAST)) begin
        rep_fire = 1'b1;
        hold_nxt = '0;
        rep_nxt  = 1'b1;
      end else begin
        hold_nxt = hold_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    to_nxt  = to_cnt;
    timeout = 1'b0;
    if (!in_set || btn_up || btn_down) begin
      to_nxt = '0;
    end else if (tick) begin
      if (to_cnt >= TIMEOUT_LAST) begin
        timeout = 1'b1;
        to_nxt  = '0;
      end else begin
        to_nxt = to_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    mode_nxt  = mode;
    inc_nxt   = 1'b0;
    dec_nxt   = 1'b0;
    alarm_nxt = alarm_en;
    if (mode > SET_AL_MIN) begin
      mode_nxt = NORMAL;
    end else if (press_mode) begin
      mode_nxt = mode_adv;
    end else begin
      if (timeout) mode_nxt = NORMAL;
      // Fixed priority; any fresh press suppresses a same-cycle repeat.
      if (press_alarm) begin
        if (!in_set) alarm_nxt = ~alarm_en;
      end else if (press_up) begin
        inc_nxt = in_set;
      end else if (press_down) begin
        dec_nxt = in_set;
      end else if (rep_fire) begin
        inc_nxt = btn_up;
        dec_nxt = btn_down;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_mode  <= 1'b0;
      prev_up    <= 1'b0;
      prev_down  <= 1'b0;
      prev_alarm <= 1'b0;
      mode       <= NORMAL;
      inc_pulse  <= 1'b0;
      dec_pulse  <= 1'b0;
      alarm_en   <= 1'b0;
      hold_cnt   <= '0;
      repeating  <= 1'b0;
      to_cnt     <= '0;
    end else begin
      prev_mode  <= btn_mode;
      prev_up    <= btn_up;
      prev_down  <= btn_down;
      prev_alarm <= btn_alarm;
      mode       <= mode_nxt;
      inc_pulse  <= inc_nxt;
      dec_pulse  <= dec_nxt;
      alarm_en   <= alarm_nxt;
      hold_cnt   <= press_mode ? '0 : hold_nxt;
      repeating  <= press_mode ? 1'b0 : rep_nxt;
      to_cnt     <= press_mode ? '0 : to_nxt;
    end
  end

endmodule

// File: tb/tb_button_sequencer.sv
// Directed bench for button_sequencer with short hold/repeat/timeout parameters.
module tb_button_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       tick = 1'b0;
  logic       btn_mode = 1'b0, btn_up = 1'b0, btn_down = 1'b0, btn_alarm = 1'b0;
  logic [2:0] mode;
  logic       inc_pulse, dec_pulse, alarm_en;

  int checks = 0;
  int errors = 0;

  button_sequencer #(
    .HOLD_TICKS(4), .REPEAT_TICKS(2), .TIMEOUT_TICKS(8), .CNT_W(10)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick),
    .btn_mode(btn_mode), .btn_up(btn_up), .btn_down(btn_down), .btn_alarm(btn_alarm),
    .mode(mode), .inc_pulse(inc_pulse), .dec_pulse(dec_pulse), .alarm_en(alarm_en)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       m, u, d, a, t;
    logic [2:0] e_mode;
    logic       e_inc, e_dec, e_al;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic m, u, d, a, t, input logic [2:0] em, input logic ei, ed, ea);
    vec_t v;
    v.m = m; v.u = u; v.d = d; v.a = a; v.t = t;
    v.e_mode = em; v.e_inc = ei; v.e_dec = ed; v.e_al = ea;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_out(input string name, input logic [2:0] em, input logic ei, ed, ea);
    check({name, ".mode"}, int'(mode), int'(em));
    check({name, ".inc"}, int'(inc_pulse), int'(ei));
    check({name, ".dec"}, int'(dec_pulse), int'(ed));
    check({name, ".alarm_en"}, int'(alarm_en), int'(ea));
  endtask

  // Inputs are driven 1 time unit after a rising edge; outputs are sampled at the same point.
  task automatic step(input logic m, u, d, a, t);
    btn_mode = m; btn_up = u; btn_down = d; btn_alarm = a; tick = t;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    btn_mode = 0; btn_up = 0; btn_down = 0; btn_alarm = 0; tick = 0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_out("reset", 3'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic goto_mode(input int n);
    for (int i = 0; i < n; i++) begin
      step(1, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
    end
  endtask

  initial begin
    // Mode cycle, alarm toggle, NORMAL up ignored, same-cycle arbitration.
    add(1,0,0,0,0, 3'd1,0,0,0); add(0,0,0,0,0, 3'd1,0,0,0);
    add(1,0,0,0,0, 3'd2,0,0,0); add(0,0,0,0,0, 3'd2,0,0,0);
    add(1,0,0,0,0, 3'd3,0,0,0); add(0,0,0,0,0, 3'd3,0,0,0);
    add(1,0,0,0,0, 3'd4,0,0,0); add(0,0,0,0,0, 3'd4,0,0,0);
    add(1,0,0,0,0, 3'd0,0,0,0); add(0,0,0,0,0, 3'd0,0,0,0);
    add(0,0,0,1,0, 3'd0,0,0,1); add(0,0,0,0,0, 3'd0,0,0,1);
    add(0,0,0,1,0, 3'd0,0,0,0); add(0,0,0,0,0, 3'd0,0,0,0);
    add(0,1,0,0,0, 3'd0,0,0,0); add(0,0,0,0,0, 3'd0,0,0,0);
    add(0,0,1,0,0, 3'd0,0,0,0); add(0,0,0,0,0, 3'd0,0,0,0);
    add(1,0,0,0,0, 3'd1,0,0,0); add(0,0,0,0,0, 3'd1,0,0,0);
    add(1,1,0,0,0, 3'd2,0,0,0); add(0,0,0,0,0, 3'd2,0,0,0);
    add(0,1,1,0,0, 3'd2,1,0,0); add(0,0,0,0,0, 3'd2,0,0,0);
    add(0,0,1,0,0, 3'd2,0,1,0); add(0,0,1,0,0, 3'd2,0,0,0);
    add(0,0,0,0,0, 3'd2,0,0,0);
    add(0,1,0,1,0, 3'd2,0,0,0); add(0,0,0,0,0, 3'd2,0,0,0);

    #2 rst_n = 1'b0;
    do_reset();
    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].m, vecs[i].u, vecs[i].d, vecs[i].a, vecs[i].t);
      check_out($sformatf("vec%0d", i), vecs[i].e_mode, vecs[i].e_inc, vecs[i].e_dec, vecs[i].e_al);
    end

    // Hold-to-repeat in SET_HR: pulses at press, ticks 4, 6, 8, 10; no timeout while held.
    do_reset();
    goto_mode(1);
    step(0, 1, 0, 0, 0);
    check_out("hold.press", 3'd1, 1'b1, 1'b0, 1'b0);
    for (int t = 1; t <= 10; t++) begin
      step(0, 1, 0, 0, 1);
      check_out($sformatf("hold.tick%0d", t), 3'd1, (t >= 4 && t % 2 == 0), 1'b0, 1'b0);
      step(0, 1, 0, 0, 0);
      check_out($sformatf("hold.gap%0d", t), 3'd1, 1'b0, 1'b0, 1'b0);
    end
    for (int t = 0; t < 3; t++) begin
      step(0, 0, 0, 0, 1);
      check_out($sformatf("release%0d", t), 3'd1, 1'b0, 1'b0, 1'b0);
    end

    // Timeout after 8 idle ticks in SET_MIN.
    do_reset();
    goto_mode(2);
    for (int t = 1; t <= 8; t++) begin
      step(0, 0, 0, 0, 1);
      check($sformatf("timeout.tick%0d", t), int'(mode), (t == 8) ? 0 : 2);
      step(0, 0, 0, 0, 0);
    end

    // An up press restarts the idle count.
    do_reset();
    goto_mode(2);
    for (int t = 0; t < 5; t++) begin
      step(0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0);
    end
    step(0, 1, 0, 0, 0);
    check_out("restart.press", 3'd2, 1'b1, 1'b0, 1'b0);
    step(0, 0, 0, 0, 0);
    for (int t = 1; t <= 8; t++) begin
      step(0, 0, 0, 0, 1);
      check($sformatf("restart.tick%0d", t), int'(mode), (t == 8) ? 0 : 2);
      step(0, 0, 0, 0, 0);
    end

    // Mode press coinciding with the timeout tick wins.
    do_reset();
    goto_mode(2);
    for (int t = 0; t < 7; t++) step(0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1);
    check("timeout_vs_mode", int'(mode), 3);

    // Async reset mid-hold in SET_AL_HR, with the button still held at release.
    do_reset();
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);
    check("arm.alarm_en", int'(alarm_en), 1);
    goto_mode(3);
    step(0, 0, 1, 0, 0);
    check_out("down.press", 3'd3, 1'b0, 1'b1, 1'b1);
    for (int t = 1; t <= 4; t++) step(0, 0, 1, 0, 1);
    check_out("down.tick4", 3'd3, 1'b0, 1'b1, 1'b1);
    rst_n = 1'b0;
    #1;
    check_out("async_reset", 3'd0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int t = 0; t < 6; t++) begin
      step(0, 0, 1, 0, 1);
      check_out($sformatf("post_reset%0d", t), 3'd0, 1'b0, 1'b0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
